// File: rtl/data_sram_resp_pkg.sv
// Shared types and constants for the handshaked data SRAM responder.
package data_sram_pkg;

    localparam int LAT_DEF    = 2;
    localparam int QDEPTH_DEF = 2;
    localparam int IDX_W      = 30;

    // Fibonacci taps for x^16+x^14+x^13+x^11+1, shifting left
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef struct packed {
        logic             wr;
        logic [3:0]       wstrb;
        logic [IDX_W-1:0] idx;
        logic [31:0]      wdata;
        logic [3:0]       cnt;
    } entry_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/data_sram_resp_if.sv
// Core LSU <-> data memory request/response interface.
interface data_sram_resp_if;
    logic        req;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (output req, wr, wstrb, addr, wdata, input addr_ok, data_ok, rdata);
    modport slave  (input req, wr, wstrb, addr, wdata, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/data_sram_resp_fifo.sv
// Circular queue of outstanding requests; each entry counts down to its response cycle.
module data_sram_resp_fifo
    import data_sram_pkg::*;
#(
    parameter int QDEPTH = QDEPTH_DEF,
    parameter int LAT    = LAT_DEF
) (
    input  logic   clk,
    input  logic   resetn,
    input  logic   push,
    input  logic   pop,
    input  entry_t push_ent,
    output logic   full,
    output entry_t head,
    output logic   head_ready
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(QDEPTH - 1);

    entry_t            ent [QDEPTH];
    logic [QDEPTH-1:0] vld;
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [CW-1:0]     count;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < QDEPTH; i++) ent[i] <= '0;
            vld    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            for (int i = 0; i < QDEPTH; i++)
                if (vld[i] && ent[i].cnt != 4'd0) ent[i].cnt <= ent[i].cnt - 4'd1;
            if (pop) begin
                vld[rd_ptr] <= 1'b0;
                rd_ptr      <= ptr_inc(rd_ptr);
            end
            // push never targets the popping slot: push requires !full, pop requires count > 0
            if (push) begin
                ent[wr_ptr]     <= push_ent;
                ent[wr_ptr].cnt <= 4'(LAT - 1);
                vld[wr_ptr]     <= 1'b1;
                wr_ptr          <= ptr_inc(wr_ptr);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign full       = (count == CW'(QDEPTH));
    assign head       = ent[rd_ptr];
    assign head_ready = vld[rd_ptr] && (head.cnt == 4'd0);

endmodule

// File: rtl/data_sram_resp.sv
// Fixed-latency, in-order data memory responder. Define DATA_SRAM_RESP_STALL_EN
// to add LFSR-driven random addr_ok stalls.
module data_sram_resp
    import data_sram_pkg::*;
#(
    parameter int DEPTH_LOG2 = 12,
    parameter int LAT        = LAT_DEF,
    parameter int QDEPTH     = QDEPTH_DEF
) (
    input  logic           clk,
    input  logic           resetn,
    data_sram_resp_if.slave bus
);

    entry_t                push_ent, head;
    logic                  full, head_ready, push, stall;
    logic [DEPTH_LOG2-1:0] head_idx;
    logic [31:0]           mem [2**DEPTH_LOG2];
    logic                  unused_bits;

`ifdef DATA_SRAM_RESP_STALL_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) lfsr <= LFSR_SEED;
        else         lfsr <= lfsr_next(lfsr);
    end

    assign stall = (lfsr[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    // occupancy only, no bypass of a same-cycle pop
    assign bus.addr_ok = resetn & ~full & ~stall;
    assign push        = bus.req & bus.addr_ok;

    always_comb begin
        push_ent       = '0;
        push_ent.wr    = bus.wr;
        push_ent.wstrb = bus.wstrb;
        push_ent.idx   = bus.addr[31:2];
        push_ent.wdata = bus.wdata;
    end

    data_sram_resp_fifo #(.QDEPTH(QDEPTH), .LAT(LAT)) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push),
        .pop       (head_ready),
        .push_ent  (push_ent),
        .full      (full),
        .head      (head),
        .head_ready(head_ready)
    );

    assign head_idx    = head.idx[DEPTH_LOG2-1:0];
    assign bus.data_ok = head_ready;
    assign bus.rdata   = (head_ready && !head.wr) ? mem[head_idx] : 32'h0;

    // writes commit only when their response goes out, keeping service strictly in order
    always_ff @(posedge clk) begin
        if (head_ready && head.wr)
            for (int b = 0; b < 4; b++)
                if (head.wstrb[b]) mem[head_idx][8*b +: 8] <= head.wdata[8*b +: 8];
    end

    assign unused_bits = ^{bus.addr[1:0], head};

endmodule

// File: tb/tb_data_sram_resp.sv
// Bench for data_sram_resp: LAT=2 and LAT=3 instances against an in-order scoreboard.
module tb_data_sram_resp;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    data_sram_resp_if b0();
    data_sram_resp_if b1();

    data_sram_resp #(.DEPTH_LOG2(12), .LAT(2), .QDEPTH(2)) u0 (.clk(clk), .resetn(resetn), .bus(b0));
    data_sram_resp #(.DEPTH_LOG2(12), .LAT(3), .QDEPTH(2)) u1 (.clk(clk), .resetn(resetn), .bus(b1));

    typedef struct packed {
        logic        w;
        logic [3:0]  s;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic        w;
        logic [3:0]  s;
        int          key;
        logic [31:0] wd;
        int          acc;
    } sb_t;

    sb_t         q0[$], q1[$];
    logic [31:0] mmem   [int];
    logic [3:0]  mknown [int];
    int vectors = 0, miscompares = 0, cyc = 0, stalls = 0;

    logic        ao_h [8];
    logic        dk_h [8];
    logic [31:0] rd_h [8];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic ao_of(input int d);
        return (d == 0) ? b0.addr_ok : b1.addr_ok;
    endfunction
    function automatic logic dk_of(input int d);
        return (d == 0) ? b0.data_ok : b1.data_ok;
    endfunction
    function automatic logic [31:0] rd_of(input int d);
        return (d == 0) ? b0.rdata : b1.rdata;
    endfunction
    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : 3;
    endfunction

    task automatic drv(input int d, input logic rq, input vec_t v);
        if (d == 0) begin
            b0.req = rq; b0.wr = v.w; b0.wstrb = v.s; b0.addr = v.a; b0.wdata = v.d;
        end else begin
            b1.req = rq; b1.wr = v.w; b1.wstrb = v.s; b1.addr = v.a; b1.wdata = v.d;
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [3:0] s, input logic [31:0] a,
                                input logic [31:0] d, input logic [31:0] exp);
        vec_t v;
        v.w = w; v.s = s; v.a = a; v.d = d; v.exp = exp;
        return v;
    endfunction

    function automatic vec_t rnd_vec();
        vec_t v;
        v.w   = 1'($urandom_range(0, 1));
        v.s   = 4'($urandom);
        v.a   = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
        v.d   = $urandom;
        v.exp = 32'h0;
        return v;
    endfunction

    // Reference: every accepted request answers exactly LAT cycles later, in order;
    // memory image is updated when a write answers.
    task automatic mon(input int d);
        logic        rq, ao, dk;
        logic [31:0] a, rd, m, mask;
        logic [3:0]  kn;
        sb_t         e, h;
        int          occ;
        if (d == 0) begin
            rq = b0.req; ao = b0.addr_ok; dk = b0.data_ok; rd = b0.rdata; a = b0.addr;
            e.w = b0.wr; e.s = b0.wstrb; e.wd = b0.wdata; occ = q0.size();
        end else begin
            rq = b1.req; ao = b1.addr_ok; dk = b1.data_ok; rd = b1.rdata; a = b1.addr;
            e.w = b1.wr; e.s = b1.wstrb; e.wd = b1.wdata; occ = q1.size();
        end
        e.key = d * 4096 + int'(a[13:2]);
        e.acc = cyc;
        if (!resetn) begin
            if (d == 0) q0.delete(); else q1.delete();
            check($sformatf("u%0d reset data_ok", d), dk, 0);
            check($sformatf("u%0d reset rdata", d), rd, 0);
            return;
        end
`ifdef DATA_SRAM_RESP_STALL_EN
        if (rq && !ao && occ < 2) stalls++;
`else
        check($sformatf("u%0d addr_ok occ=%0d", d, occ), ao, occ < 2);
`endif
        if (dk) begin
            if (occ == 0) check($sformatf("u%0d data_ok with nothing outstanding", d), 1, 0);
            else begin
                if (d == 0) h = q0.pop_front(); else h = q1.pop_front();
                check($sformatf("u%0d latency", d), cyc - h.acc, lat_of(d));
                m  = mmem.exists(h.key) ? mmem[h.key] : 32'h0;
                kn = mknown.exists(h.key) ? mknown[h.key] : 4'h0;
                if (h.w) begin
                    check($sformatf("u%0d write rdata", d), rd, 0);
                    for (int b = 0; b < 4; b++)
                        if (h.s[b]) begin m[8*b +: 8] = h.wd[8*b +: 8]; kn[b] = 1'b1; end
                    mmem[h.key]   = m;
                    mknown[h.key] = kn;
                end else begin
                    mask = {{8{kn[3]}}, {8{kn[2]}}, {8{kn[1]}}, {8{kn[0]}}};
                    if (mask != 0) check($sformatf("u%0d read rdata key=%0d", d, h.key), rd & mask, m & mask);
                end
            end
        end else check($sformatf("u%0d idle rdata", d), rd, 0);
        if (rq && ao) begin
            if (d == 0) q0.push_back(e); else q1.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    task automatic txn(input int d, input vec_t v, input string nm);
        int k;
        @(posedge clk); #1;
        drv(d, 1'b1, v);
        k = 0;
        @(negedge clk);
        while (!ao_of(d) && k < 100) begin @(negedge clk); k++; end
        if (!ao_of(d)) begin
            check({nm, " accept"}, 0, 1);
            drv(d, 1'b0, v);
            return;
        end
        @(posedge clk); #1;
        drv(d, 1'b0, v);
        k = 0;
        do begin @(negedge clk); k++; end while (!dk_of(d) && k < 100);
        check({nm, " latency"}, k, lat_of(d));
        check({nm, " rdata"}, rd_of(d), v.exp);
    endtask

    // Holds req high through the list; records the first 8 cycles of handshake outputs.
    task automatic burst(input int d, input vec_t r [3], input int n);
        int i = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            drv(d, i < n, r[(i < n) ? i : 0]);
            @(negedge clk);
            if (c < 8) begin ao_h[c] = ao_of(d); dk_h[c] = dk_of(d); rd_h[c] = rd_of(d); end
            if (i < n && ao_of(d)) i++;
        end
        check($sformatf("u%0d burst accepted", d), i, n);
    endtask

    task automatic cmp_hist(input string nm, input int eao [8], input int edk [8], input logic [31:0] erd [8]);
        for (int c = 0; c < 8; c++) begin
            check($sformatf("%s addr_ok c%0d", nm, c), ao_h[c], eao[c]);
            check($sformatf("%s data_ok c%0d", nm, c), dk_h[c], edk[c]);
            check($sformatf("%s rdata c%0d", nm, c), rd_h[c], erd[c]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1);
    end

    initial begin
        vec_t tbl [12];
        vec_t br [3];
        vec_t idle, wa, wb;
        int   acc, guard, i;

        idle = mk(0, 4'h0, 32'h0, 32'h0, 32'h0);
        tbl[0]  = mk(1, 4'hF, 32'h1c00_0010, 32'hDEAD_BEEF, 32'h0);
        tbl[1]  = mk(0, 4'h0, 32'h1c00_0010, 32'h0,         32'hDEAD_BEEF);
        tbl[2]  = mk(0, 4'h0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF);
        tbl[3]  = mk(0, 4'h0, 32'hFFFF_C010, 32'h0,         32'hDEAD_BEEF);
        tbl[4]  = mk(1, 4'hF, 32'h0000_0020, 32'h1122_3344, 32'h0);
        tbl[5]  = mk(1, 4'h5, 32'h0000_0020, 32'hAABB_CCDD, 32'h0);
        tbl[6]  = mk(0, 4'h0, 32'h0000_0020, 32'h0,         32'h11BB_33DD);
        tbl[7]  = mk(1, 4'h8, 32'h0000_0022, 32'h9900_0000, 32'h0);
        tbl[8]  = mk(0, 4'h0, 32'h0000_0020, 32'h0,         32'h99BB_33DD);
        tbl[9]  = mk(1, 4'hF, 32'h0000_0024, 32'h1234_5678, 32'h0);
        tbl[10] = mk(1, 4'h0, 32'h0000_0024, 32'hFFFF_FFFF, 32'h0);
        tbl[11] = mk(0, 4'h0, 32'h0000_0024, 32'h0,         32'h1234_5678);

        // reset held with req asserted
        drv(0, 1'b1, tbl[1]);
        drv(1, 1'b1, tbl[1]);
        repeat (3) begin
            @(negedge clk);
            check("rst u0 addr_ok", b0.addr_ok, 0);
            check("rst u1 addr_ok", b1.addr_ok, 0);
            check("rst u0 data_ok", b0.data_ok, 0);
            check("rst u0 rdata", b0.rdata, 0);
        end
        @(posedge clk); #1;
        drv(0, 1'b0, idle);
        drv(1, 1'b0, idle);
        resetn = 1'b1;
        @(negedge clk);
        check("post-reset u0 addr_ok", b0.addr_ok, 1);
        check("post-reset u1 addr_ok", b1.addr_ok, 1);

        for (int t = 0; t < 12; t++) txn(0, tbl[t], $sformatf("tbl%0d", t));

        // pipelined write then read of the same word (LAT=2)
        br[0] = mk(1, 4'hF, 32'h1c00_0010, 32'hCAFE_F00D, 32'h0);
        br[1] = mk(0, 4'h0, 32'h1c00_0010, 32'h0, 32'h0);
        br[2] = idle;
        burst(0, br, 2);
`ifndef DATA_SRAM_RESP_STALL_EN
        cmp_hist("wr->rd", '{1,1,0,1,1,1,1,1}, '{0,0,1,1,0,0,0,0},
                 '{32'h0, 32'h0, 32'h0, 32'hCAFE_F00D, 32'h0, 32'h0, 32'h0, 32'h0});
`endif

        // back-pressure on the LAT=3, QDEPTH=2 instance
        txn(1, mk(1, 4'hF, 32'h0, 32'hA0A0_A0A0, 32'h0), "u1 pre0");
        txn(1, mk(1, 4'hF, 32'h4, 32'hB1B1_B1B1, 32'h0), "u1 pre4");
        txn(1, mk(1, 4'hF, 32'h8, 32'hC2C2_C2C2, 32'h0), "u1 pre8");
        br[0] = mk(0, 4'h0, 32'h0, 32'h0, 32'h0);
        br[1] = mk(0, 4'h0, 32'h4, 32'h0, 32'h0);
        br[2] = mk(0, 4'h0, 32'h8, 32'h0, 32'h0);
        burst(1, br, 3);
`ifndef DATA_SRAM_RESP_STALL_EN
        cmp_hist("bp", '{1,1,0,0,1,1,1,1}, '{0,0,0,1,1,0,0,1},
                 '{32'h0, 32'h0, 32'h0, 32'hA0A0_A0A0, 32'hB1B1_B1B1, 32'h0, 32'h0, 32'hC2C2_C2C2});
`endif

        // reset with two writes in flight: neither may commit
        txn(0, mk(1, 4'hF, 32'h40, 32'h0101_0101, 32'h0), "pre40");
        txn(0, mk(1, 4'hF, 32'h44, 32'h0202_0202, 32'h0), "pre44");
        wa = mk(1, 4'hF, 32'h40, 32'hFFFF_FFFF, 32'h0);
        wb = mk(1, 4'hF, 32'h44, 32'hEEEE_EEEE, 32'h0);
        i = 0;
        for (int c = 0; c < 40 && i < 2; c++) begin
            @(posedge clk); #1;
            drv(0, 1'b1, (i == 0) ? wa : wb);
            @(negedge clk);
            if (b0.addr_ok) i++;
        end
        check("midrst both accepted", i, 2);
        @(posedge clk); #1;
        drv(0, 1'b0, idle);
`ifndef DATA_SRAM_RESP_STALL_EN
        check("midrst pre data_ok", b0.data_ok, 1);
`endif
        #1 resetn = 1'b0;
        #1;
        check("midrst data_ok", b0.data_ok, 0);
        check("midrst addr_ok", b0.addr_ok, 0);
        check("midrst rdata", b0.rdata, 0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        txn(0, mk(0, 4'h0, 32'h40, 32'h0, 32'h0101_0101), "midrst rd40");
        txn(0, mk(0, 4'h0, 32'h44, 32'h0, 32'h0202_0202), "midrst rd44");

        // random traffic on both instances
        acc = 0;
        guard = 0;
        while (acc < 1000 && guard < 20000) begin
            @(posedge clk); #1;
            drv(0, $urandom_range(0, 3) != 0, rnd_vec());
            drv(1, $urandom_range(0, 3) != 0, rnd_vec());
            @(negedge clk);
            if (b0.req && b0.addr_ok) acc++;
            guard++;
        end
        check("random accepted", acc, 1000);
        @(posedge clk); #1;
        drv(0, 1'b0, idle);
        drv(1, 1'b0, idle);
        repeat (10) @(negedge clk);
        check("u0 drained", q0.size(), 0);
        check("u1 drained", q1.size(), 0);
`ifdef DATA_SRAM_RESP_STALL_EN
        check("stall cycle seen", stalls > 0, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
